// File: rtl/multimode_shift_register.sv
// Universal W-bit shift register: hold/shift/rotate/arith-shift/load plus LSB-first serialiser.
// Latency: single ops take effect on the edge that samples en=1; SER runs W further edges.
// Backpressure: busy is high during SER and commands are ignored until done pulses.
module multimode_shift_register #(
  parameter int W  = 8,
  parameter int AW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [2:0]    op,
  input  logic [AW-1:0] amt,
  input  logic [W-1:0]  in,
  input  logic          msb,
  input  logic          lsb,
  output logic [W-1:0]  out,
  output logic          co,
  output logic          zero,
  output logic          busy,
  output logic          done
);

  localparam int CW   = $clog2(W + 1);
  localparam int KMAX = W - 1;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_SER  = 3'b111;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   nxt;
  logic           nco;
  int             k;

  // Amounts past the top bit saturate to W-1 so every op stays well defined
  always_comb begin
    k = (int'(amt) > KMAX) ? KMAX : int'(amt);
  end

  // Next value and shift-out bit for the single-cycle ops; k = 0 leaves both untouched
  always_comb begin
    nxt = out;
    nco = co;
    if (k != 0) begin
      case (op)
        OP_SHR, OP_ASR: begin
          for (int i = 0; i < W; i++) begin
            if (i + k < W)        nxt[i] = out[i + k];
            else if (op == OP_ASR) nxt[i] = out[W-1];
            else                  nxt[i] = msb;
            if (i == k - 1)       nco    = out[i];
          end
        end
        OP_ROR: begin
          for (int i = 0; i < W; i++) begin
            nxt[i] = (i + k < W) ? out[i + k] : out[i + k - W];
            if (i == k - 1) nco = out[i];
          end
        end
        OP_SHL: begin
          for (int i = 0; i < W; i++) begin
            nxt[i] = (i >= k) ? out[i - k] : lsb;
            if (i == W - k) nco = out[i];
          end
        end
        OP_ROL: begin
          for (int i = 0; i < W; i++) begin
            nxt[i] = (i >= k) ? out[i - k] : out[i - k + W];
            if (i == W - k) nco = out[i];
          end
        end
        default: begin
          nxt = out;
          nco = co;
        end
      endcase
    end
  end

  // Command decode while idle, then W self-timed LSB-first shifts for SER
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= '0;
      co    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (en) begin
            case (op)
              OP_HOLD: ;
              OP_LOAD: begin
                out <= in;
                co  <= 1'b0;
              end
              OP_SER: begin
                out   <= in;
                co    <= 1'b0;
                busy  <= 1'b1;
                cnt   <= CW'(W);
                state <= SHIFT;
              end
              default: begin
                out <= nxt;
                co  <= nco;
              end
            endcase
          end
        end
        SHIFT: begin
          out <= {msb, out[W-1:1]};
          co  <= out[0];
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zero = (out == '0);

endmodule

// File: doc/multimode_shift_register.md
# multimode_shift_register

Parametrised, next-generation universal shift register. Adds multi-bit shift amounts, rotates, arithmetic right shift, a carry/shift-out flag and a self-timed parallel-to-serial mode with busy/done handshake. Sits in the datapath wherever a W-bit value must be held, realigned or serialised LSB-first. Op codes 000-011 keep the legacy hold / shift-right / shift-left / load semantics when amt = 1.

## Interface
- W, default 8: register width; legal range W ≥ 2.
- AW, default $clog2(W): width of the shift-amount input.
- clk  input  1: single clock; all state updates on its rising edge.
- reset  input  1: asynchronous, active-high reset.
- en  input  1: command enable, sampled while idle.
- op  input  3: operation code.
- amt  input  AW: shift/rotate amount k. Valid range 0..W-1; values ≥ W are saturated to W-1.
- in  input  W: parallel load data.
- msb  input  1: serial fill bit for right shifts and SER.
- lsb  input  1: serial fill bit for left shifts.
- out  output  W: register contents.
- co  output  1: last bit shifted or rotated out; registered.
- zero  output  1: combinational, high when out == 0.
- busy  output  1: high while a SER sequence runs.
- done  output  1: one-cycle pulse when a SER sequence completes.

## Operation
- Reset values: out = 0, co = 0, busy = 0, done = 0, FSM = IDLE, internal bit counter = 0.
- IDLE, en = 0: all state holds and done = 0.
- IDLE, en = 1: execute op with k = amt.
  - 000 HOLD: no change.
  - 001 SHR: out = {k×msb, out[W-1:k]}; co = out[k-1].
  - 010 SHL: out = {out[W-1-k:0], k×lsb}; co = out[W-k].
  - 011 LOAD: out = in; co = 0.
  - 100 ROR: rotate right by k; co = out[k-1].
  - 101 ROL: rotate left by k; co = out[W-k].
  - 110 ASR: fill with the old out[W-1]; co = out[k-1].
  - 111 SER: out = in, co = 0, busy = 1, counter = W, FSM → SHIFT.
- k = 0 for ops 001, 010, 100, 101, 110: out and co unchanged.
- SHIFT state, every edge:
  - out = {msb, out[W-1:1]}, co = out[0], counter decrements.
  - en, op, amt and in are ignored.
- When the counter goes 1 → 0 on an edge, the same edge sets busy = 0, done = 1 and FSM → IDLE.
- done is cleared on the next edge.
- A new command is accepted on the edge where done = 1.
- All arithmetic is unsigned except ASR's sign fill; there are no overflow flags.

## Timing
- Single-op latency: 1 cycle. Results are visible on out/co after the edge that samples en = 1.
- zero follows out combinationally.
- SER sequence:
  - Load edge L: busy rises.
  - Edges L+1 .. L+W perform the W shifts; after edge L+i, co = in[i-1] (LSB first).
  - busy falls and done rises after edge L+W.
  - busy is high for exactly W cycles; done is high for exactly 1 cycle.
- Reset mid-operation: asynchronous reset forces all outputs and the FSM to reset values immediately. done is not pulsed, and the aborted sequence is lost.
- A simultaneous reset and command: reset wins.

## Test plan
W = 8 for all scenarios.
- Reset, then LOAD in = 0xA5 → out = 0xA5, co = 0, zero = 0. Then HOLD → unchanged.
- From 0xA5, SHR amt = 3, msb = 1 → out = 0xF4, co = 1. Then SHL amt = 2, lsb = 0 → out = 0xD0, co = 1.
- Rotate and arithmetic shifts:
  - From 0x81, ROL amt = 1 → out = 0x03, co = 1.
  - ROR amt = 4 on 0x3C → out = 0xC3, co = 1.
  - From 0x90, ASR amt = 2 → out = 0xE4, co = 0.
- SER in = 0xB4, msb = 0, op toggled randomly while busy:
  - busy is high for 8 cycles.
  - co sequence is 0,0,1,0,1,1,0,1.
  - done pulses once and out = 0x00 with zero = 1.
  - Commands issued while busy have no effect.
- Reset asserted between clock edges during SER cycle 4 → out, co and busy go to 0 before the next edge, and done never rises. A following LOAD 0x5A → out = 0x5A.
- en = 0 with op = SHL, amt = 3 → no change. en = 1 with ROR amt = 0 → out and co unchanged. amt = 9 (if AW permits) → treated as 7.
